// File: rtl/microwave_pkg.sv
// microwave_pkg: controller state encodings (IDLE..DONE, 3 bits) and highest accepted keypad digit
package microwave_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: holdable 0..CLK_PER_SEC-1 counter; clock/clr(sync reset), run(advance), clear(zero) in, tick(wrap this cycle) out
module sec_tick_gen #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic clr,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int W = CLK_PER_SEC > 1 ? $clog2(CLK_PER_SEC) : 1;
  logic [W-1:0] cnt;
  assign tick = run && cnt == W'(CLK_PER_SEC - 1);
  always_ff @(posedge clock)
    if (clr || clear) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/microwave_controller.sv
// microwave_controller: keypad/start/stop/door sequencer driving mm:ss timer (loadn, clrn, en, data), mag_on, buzzer, state_dbg; clock, sync active-high clr
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int DONE_SECS   = 3
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_en,
  output logic [3:0] timer_data,
  output logic       mag_on,
  output logic       buzzer,
  output logic [2:0] state_dbg
);
  localparam int SW = DONE_SECS > 1 ? $clog2(DONE_SECS) : 1;
  state_t state, next;
  logic [SW-1:0] secs;
  logic run, clear, tick, go, key_ok, clr_req, last_sec;
  sec_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (
    .clock(clock),
    .clr(clr),
    .run(run),
    .clear(clear),
    .tick(tick)
  );
  always_comb begin
    go = start && door_closed && !timer_zero;
    run = !stop && door_closed && (state == COOK ? !timer_zero : state == DONE ? !start : 1'b0);
    last_sec = secs == SW'(DONE_SECS - 1);
    key_ok = key_valid && key_code <= KEY_MAX_DIGIT && !stop && (state == IDLE || (state == ENTRY && !go));
    clr_req = stop && (state == IDLE || state == ENTRY || state == PAUSE);
    next = state;
    case (state)
      IDLE:    next = key_ok ? ENTRY : IDLE;
      ENTRY:   next = stop ? IDLE : go ? COOK : ENTRY;
      COOK:    next = stop || !door_closed ? PAUSE : timer_zero ? DONE : COOK;
      PAUSE:   next = stop ? IDLE : go ? COOK : PAUSE;
      DONE:    next = stop || start || !door_closed || (tick && last_sec) ? IDLE : DONE;
      default: next = IDLE;
    endcase
    clear = (state == ENTRY && next == COOK) || (state == COOK && next == DONE);
  end
  always_ff @(posedge clock)
    if (clr) begin
      state       <= IDLE;
      secs        <= '0;
      mag_on      <= 1'b0;
      buzzer      <= 1'b0;
      timer_en    <= 1'b0;
      timer_loadn <= 1'b1;
      timer_data  <= 4'd0;
      timer_clrn  <= 1'b0;
    end else begin
      state       <= next;
      secs        <= clear ? '0 : tick && state == DONE ? secs + 1'b1 : secs;
      mag_on      <= next == COOK;
      buzzer      <= next == DONE;
      timer_en    <= tick && state == COOK;
      timer_loadn <= !key_ok;
      timer_data  <= key_ok ? key_code : 4'd0;
      timer_clrn  <= !clr_req;
    end
  assign state_dbg = state;
endmodule

// File: doc/microwave_controller.md
Name: microwave_controller

Overview:
Top-level sequencer for the mm:ss countdown timer chain (units, tens-of-seconds and minutes digits; load, active-low clear, enable; zero flag). It accepts keypad digits and shifts them into the timer, generates the 1 Hz count enable, and runs the cook / pause / done cycle. It also drives the magnetron and buzzer outputs.

Parameters:
CLK_PER_SEC, 50_000_000, clock cycles per timer decrement (tick period)
DONE_SECS, 3, seconds the buzzer sounds after cooking ends

Ports:
clock  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
key_valid  in  1  one-cycle strobe: key_code is valid
key_code  in  4  keypad code; 0-9 are digits, 10-15 are ignored
start  in  1  one-cycle start strobe
stop  in  1  one-cycle stop/cancel strobe
door_closed  in  1  level: 1 = door shut
timer_zero  in  1  timer reads 0:00
timer_loadn  out  1  active-low load to timer (shifts in one digit)
timer_clrn  out  1  active-low clear to timer
timer_en  out  1  timer decrement enable
timer_data  out  4  digit presented to the timer units stage
mag_on  out  1  magnetron enable
buzzer  out  1  end-of-cook buzzer
state_dbg  out  3  current state encoding

Behaviour:
- One clock domain. Reset is synchronous and active-high (clr). All outputs are registered.
- Reset values:
  - state IDLE; mag_on 0; buzzer 0; timer_en 0; timer_loadn 1; timer_data 0
  - timer_clrn 0 while clr is high; it returns to 1 on the first edge with clr low
  - tick counter 0
- States:
  - IDLE=0: time empty, waiting for digits.
  - ENTRY=1: one or more digits entered.
  - COOK=2, PAUSE=3, DONE=4.
- Digit entry (IDLE/ENTRY only):
  - A valid digit key accepted at edge N gives timer_loadn=0 and timer_data=key_code for exactly cycle N+1. The timer shift is units->tens->minutes.
  - A fourth or later digit shifts the oldest digit out; this is not an error.
  - IDLE->ENTRY on the first digit.
  - key_code>9 is ignored. Keys are ignored in COOK/PAUSE/DONE.
- start:
  - ENTRY->COOK when door_closed=1 and timer_zero=0; otherwise ignored.
  - PAUSE->COOK under the same condition.
  - Ignored in IDLE.
- stop:
  - COOK->PAUSE.
  - From IDLE/ENTRY/PAUSE: timer_clrn=0 for one cycle, then IDLE.
  - DONE->IDLE.
  - If stop and start arrive in the same cycle, stop wins.
- Door:
  - door_closed=0 in COOK -> PAUSE on the next edge.
  - Door state does not affect IDLE/ENTRY.
  - Door opening in DONE -> IDLE.
- COOK:
  - mag_on=1.
  - The tick counter runs 0..CLK_PER_SEC-1. timer_en=1 for one cycle when it wraps.
  - The counter is held (not cleared) in PAUSE and resumes from its held value.
  - The counter is cleared on entry from ENTRY.
  - timer_zero=1 sampled in COOK -> DONE. mag_on=0 and timer_en=0 from that edge.
- PAUSE: mag_on=0, timer_en=0; timer contents are preserved.
- DONE:
  - buzzer=1. The tick counter is reused to count DONE_SECS full seconds; then buzzer=0 and -> IDLE.
  - Any start, stop, or door opening ends DONE early -> IDLE.
- clr mid-cook: next cycle is IDLE with mag_on=0, and the timer is cleared via timer_clrn.
- Event priority, highest first: clr > stop > door-open > timer_zero > start > key.

Decomposition:
- Package microwave_pkg holds:
  - state typedef with IDLE..DONE encodings (3 bits)
  - KEY_MAX_DIGIT=9
- Sub-module sec_tick_gen:
  - parameter CLK_PER_SEC
  - inputs run and clear; output tick pulse
  - width $clog2(CLK_PER_SEC)
- The controller FSM instantiates sec_tick_gen and is wired beside the timer at the top level.

Test Plan:
All scenarios use CLK_PER_SEC=4 and DONE_SECS=2.
- Reset: hold clr 3 cycles -> state_dbg=0, timer_clrn=0 during clr, then 1; all other outputs at reset values.
- Keys 1,3,0 then 12 -> three single-cycle timer_loadn pulses with timer_data 1,3,0. The 12 produces no pulse. Timer reads 1:30; state ENTRY.
- Load 0:02 and start with door closed:
  - mag_on=1 next cycle
  - timer_en pulses every 4 cycles
  - after the 2nd pulse timer_zero=1 -> DONE, mag_on=0, buzzer=1 for 8 cycles, then IDLE
- Door opened mid-cook at 0:05 -> PAUSE next edge, mag_on=0, no timer_en. Close door and start -> COOK, and the first timer_en arrives after the remaining held tick count.
- start and stop in the same cycle during COOK -> PAUSE (stop wins). Then stop -> timer_clrn low for 1 cycle, IDLE.
- start in IDLE, start with door open, and start with timer_zero=1 in ENTRY -> no state change, mag_on stays 0.
